// File: rtl/tetris_playfield_fsm_if.sv
// tetris_playfield_fsm_if: piece-type request handshake between the game controller and the piece counter
interface tetris_playfield_fsm_if;
   logic       piece_req_o;
   logic [2:0] piece_i;
   modport master (output piece_req_o, input piece_i);
   modport slave (input piece_req_o, output piece_i);
endinterface

// File: rtl/tetris_playfield_fsm.sv
// tetris_playfield_fsm: Tetris controller owning the locked playfield, the active piece and the game FSM
module tetris_playfield_fsm #(
   parameter int ROWS        = 20,
   parameter int COLS        = 10,
   parameter int COLOR_W     = 3,
   parameter int HIDDEN      = 1,
   parameter int READY_TICKS = 3,
   parameter int LINES_W     = 16
) (
   input  logic                         clk,
   input  logic                         nRst_i,
   input  logic                         start_i,
   input  logic                         left_i,
   input  logic                         right_i,
   input  logic                         rot_r_i,
   input  logic                         rot_l_i,
   input  logic                         tick_i,
   tetris_playfield_fsm_if.master       pc,
   output logic [2:0]                   state_o,
   output logic [ROWS*COLS*COLOR_W-1:0] grid_o,
   output logic [LINES_W-1:0]           lines_o,
   output logic                         game_over_o
);
   typedef enum logic [2:0] {S_IDLE, S_READY, S_SPAWN, S_FALL, S_LOCK, S_CLEAR, S_OVER} state_t;
   localparam int PW  = $clog2((ROWS > COLS ? ROWS : COLS) + 4) + 2;
   localparam int RIW = $clog2(ROWS);
   localparam int CIW = $clog2(COLS);
   localparam int TW  = $clog2(READY_TICKS + 1);
   localparam logic signed [PW-1:0] SPAWN_COL = PW'((COLS - 4) / 2);
   localparam logic [15:0] ROM [28] = '{
      16'h000F, 16'h4444, 16'h00F0, 16'h2222,
      16'h0066, 16'h0066, 16'h0066, 16'h0066,
      16'h0072, 16'h0262, 16'h0270, 16'h0232,
      16'h0036, 16'h0462, 16'h0360, 16'h0231,
      16'h0063, 16'h0264, 16'h0630, 16'h0132,
      16'h0071, 16'h0226, 16'h0470, 16'h0322,
      16'h0074, 16'h0622, 16'h0170, 16'h0223};
   state_t                   r_state;
   logic [2:0]               r_type;
   logic [1:0]               r_rot;
   logic signed [PW-1:0]     r_row, r_col;
   logic                     r_drop, r_req, r_over;
   logic [TW-1:0]            r_ticks;
   logic [RIW-1:0]           r_scan;
   logic [LINES_W-1:0]       r_lines;
   logic [COLOR_W-1:0]       r_cells [ROWS][COLS];
   logic [ROWS*COLS*COLOR_W-1:0] r_grid;
   logic                     w_any, w_ok, w_full, w_hidden;
   logic [2:0]               w_type;
   logic [1:0]               w_rot;
   logic signed [PW-1:0]     w_row, w_col;
   logic [15:0]              w_mask, w_pmask;
   logic [COLOR_W-1:0]       w_color;
   logic                     w_cover [ROWS][COLS];
   function automatic logic f_free(input int r, input int c);
      return r >= 0 && r < ROWS && c >= 0 && c < COLS && r_cells[RIW'(r)][CIW'(c)] == '0;
   endfunction
   // Candidate position: the spawn pose in SPAWN, otherwise the single highest-priority FALL action
   assign w_any   = left_i | right_i | rot_r_i | rot_l_i;
   assign w_type  = r_state == S_SPAWN ? (pc.piece_i == 3'd7 ? 3'd0 : pc.piece_i) : r_type;
   assign w_rot   = r_state == S_SPAWN ? 2'd0 : (left_i | right_i) ? r_rot :
                    rot_r_i ? r_rot + 2'd1 : rot_l_i ? r_rot - 2'd1 : r_rot;
   assign w_row   = r_state == S_SPAWN ? '0 : w_any ? r_row : r_row + PW'(1);
   assign w_col   = r_state == S_SPAWN ? SPAWN_COL : left_i ? r_col - PW'(1) :
                    right_i ? r_col + PW'(1) : r_col;
   assign w_mask  = ROM[{w_type, w_rot}];
   assign w_pmask = ROM[{r_type, r_rot}];
   assign w_color = COLOR_W'(r_type) + COLOR_W'(1);
   always_comb begin
      w_ok = 1'b1;
      for (int k = 0; k < 16; k++)
         if (w_mask[k] && !f_free(int'(w_row) + k / 4, int'(w_col) + k % 4)) w_ok = 1'b0;
   end
   always_comb
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            w_cover[r][c] = 1'b0;
            for (int k = 0; k < 16; k++)
               if (w_pmask[k] && int'(r_row) + k / 4 == r && int'(r_col) + k % 4 == c) w_cover[r][c] = 1'b1;
         end
   always_comb begin
      w_full   = 1'b1;
      w_hidden = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         if (r_cells[r_scan][c] == '0) w_full = 1'b0;
         for (int r = 0; r < HIDDEN; r++)
            if (r_cells[r][c] != '0) w_hidden = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge nRst_i)
      if (!nRst_i) begin
         r_state <= S_IDLE;
         r_type  <= '0;
         r_rot   <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_drop  <= 1'b0;
         r_req   <= 1'b0;
         r_over  <= 1'b0;
         r_ticks <= '0;
         r_scan  <= '0;
         r_lines <= '0;
         r_grid  <= '0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) r_cells[r][c] <= '0;
      end else begin
         r_req  <= 1'b0;
         r_over <= 1'b0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               r_grid[(r*COLS+c)*COLOR_W +: COLOR_W] <= (r_state == S_FALL && w_cover[r][c]) ? w_color : r_cells[r][c];
         case (r_state)
            S_IDLE:
               if (start_i) begin
                  r_state <= S_READY;
                  r_ticks <= '0;
               end
            S_READY:
               if (tick_i) begin
                  if (r_ticks == TW'(READY_TICKS - 1)) begin
                     r_state <= S_SPAWN;
                     r_req   <= 1'b1;
                  end else r_ticks <= r_ticks + 1'b1;
               end
            S_SPAWN: begin
               r_type  <= w_type;
               r_rot   <= '0;
               r_row   <= '0;
               r_col   <= SPAWN_COL;
               r_state <= w_ok ? S_FALL : S_OVER;
               r_over  <= !w_ok;
            end
            S_FALL: begin
               r_drop <= tick_i | (r_drop & w_any);
               if (w_ok && (w_any || r_drop)) begin
                  r_rot <= w_rot;
                  r_row <= w_row;
                  r_col <= w_col;
               end else if (!w_any && r_drop) r_state <= S_LOCK;
            end
            S_LOCK: begin
               for (int r = 0; r < ROWS; r++)
                  for (int c = 0; c < COLS; c++)
                     if (w_cover[r][c]) r_cells[r][c] <= w_color;
               r_drop  <= 1'b0;
               r_scan  <= RIW'(ROWS - 1);
               r_state <= S_CLEAR;
            end
            S_CLEAR:
               // A full row collapses the rows above it; scan stays put so the new contents are rechecked
               if (w_full) begin
                  for (int c = 0; c < COLS; c++) begin
                     r_cells[0][c] <= '0;
                     for (int r = 1; r < ROWS; r++)
                        if (r <= int'(r_scan)) r_cells[r][c] <= r_cells[r-1][c];
                  end
                  if (r_lines != '1) r_lines <= r_lines + 1'b1;
               end else if (r_scan != '0) r_scan <= r_scan - 1'b1;
               else begin
                  r_state <= w_hidden ? S_OVER : S_SPAWN;
                  r_req   <= !w_hidden;
                  r_over  <= w_hidden;
               end
            S_OVER: begin
               r_over <= !start_i;
               if (start_i) begin
                  r_state <= S_IDLE;
                  r_lines <= '0;
                  r_type  <= '0;
                  r_rot   <= '0;
                  r_row   <= '0;
                  r_col   <= '0;
                  for (int r = 0; r < ROWS; r++)
                     for (int c = 0; c < COLS; c++) r_cells[r][c] <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   assign state_o        = r_state;
   assign grid_o         = r_grid;
   assign lines_o        = r_lines;
   assign game_over_o    = r_over;
   assign pc.piece_req_o = r_req;
endmodule

// File: tb/tb_tetris_playfield_fsm.sv
// tb_tetris_playfield_fsm: directed scenarios for the playfield controller with hand-built expected grids
module tb_tetris_playfield_fsm;
   localparam int ROWS = 20, COLS = 10, CW = 3, GW = ROWS * COLS * CW;
   localparam logic [4:0] L = 5'b10000, R = 5'b01000, RR = 5'b00100, RL = 5'b00010, T = 5'b00001;
   logic clk = 1'b0, nRst = 1'b0, start = 1'b0;
   logic left = 1'b0, right = 1'b0, rot_r = 1'b0, rot_l = 1'b0, tick = 1'b0;
   logic [2:0]    state;
   logic [GW-1:0] grid, e;
   logic [15:0]   lines;
   logic          over;
   int n_vec = 0, n_bad = 0, n_clear = 0;
   tetris_playfield_fsm_if pc();
   tetris_playfield_fsm dut (
      .clk(clk), .nRst_i(nRst), .start_i(start), .left_i(left), .right_i(right),
      .rot_r_i(rot_r), .rot_l_i(rot_l), .tick_i(tick), .pc(pc),
      .state_o(state), .grid_o(grid), .lines_o(lines), .game_over_o(over));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [GW-1:0] paint(input logic [GW-1:0] g, input int r0, input int r1,
                                           input int c0, input int c1, input int v);
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++) g[(r*COLS+c)*CW +: CW] = CW'(v);
      return g;
   endfunction
   task automatic drive(input logic [4:0] v, input int n);
      {left, right, rot_r, rot_l, tick} = v;
      repeat (n) @(negedge clk);
      {left, right, rot_r, rot_l, tick} = 5'b0;
   endtask
   // Hard-drop the falling piece with a continuous tick, then wait for the next spawn or game over
   task automatic drop(input logic [2:0] nxt);
      int i;
      pc.piece_i = nxt;
      tick = 1'b1;
      for (i = 0; i < 40 && state == 3'd3; i++) @(negedge clk);
      tick = 1'b0;
      n_clear = 0;
      for (i = 0; i < 60 && state != 3'd3 && state != 3'd6; i++) begin
         if (state == 3'd5) n_clear++;
         @(negedge clk);
      end
      chk("settle", GW'(state == 3'd3 || state == 3'd6), GW'(1));
   endtask
   initial begin
      pc.piece_i = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_state", GW'(state), '0);
      chk("rst_grid", grid, '0);
      chk("rst_lines", GW'(lines), '0);
      chk("rst_req", GW'(pc.piece_req_o), '0);
      chk("rst_over", GW'(over), '0);
      nRst = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ready", GW'(state), GW'(1));
      for (int i = 0; i < 3; i++) begin
         drive(T, 1);
         chk("ready_tick", GW'(state), GW'(i == 2 ? 2 : 1));
         chk("req_pulse", GW'(pc.piece_req_o), GW'(i == 2));
      end
      @(negedge clk);
      chk("fall", GW'(state), GW'(3));
      chk("req_once", GW'(pc.piece_req_o), '0);
      @(negedge clk);
      chk("spawn_I", grid, paint('0, 0, 0, 3, 6, 1));
      drive(RR, 1);
      @(negedge clk);
      chk("rot_r", grid, paint('0, 0, 3, 5, 5, 1));
      drive(L, 10);
      @(negedge clk);
      chk("wall_I", grid, paint('0, 0, 3, 0, 0, 1));
      drive(RR, 1);
      @(negedge clk);
      chk("rot_reject", grid, paint('0, 0, 3, 0, 0, 1));
      drive(R, 1);
      drive(L | T, 1);
      drive(5'b0, 3);
      chk("prio_drop", grid, paint('0, 1, 4, 0, 0, 1));
      drive(R, 2);
      drive(RL, 1);
      @(negedge clk);
      chk("rot_l", grid, paint('0, 1, 1, 0, 3, 1));
      drop(3'd1);
      e = paint('0, 19, 19, 0, 3, 1);
      chk("lock_I", grid, e);
      drive(L, 10);
      @(negedge clk);
      chk("wall_O", grid, paint(e, 0, 1, 0, 1, 2));
      drop(3'd1);
      drive(L, 2);
      drop(3'd0);
      drive(R, 3);
      drop(3'd1);
      drive(R, 2);
      drop(3'd1);
      drive(R, 4);
      drop(3'd1);
      chk("pre_clear_lines", GW'(lines), '0);
      drop(3'd1);
      chk("lines2", GW'(lines), GW'(2));
      chk("clear_cycles", GW'(n_clear), GW'(22));
      chk("clear_grid", grid, paint(paint('0, 19, 19, 0, 3, 2), 19, 19, 6, 9, 2));
      for (int k = 0; k < 15 && state != 3'd6; k++) drop(3'd1);
      chk("over_state", GW'(state), GW'(6));
      chk("over_flag", GW'(over), GW'(1));
      chk("over_lines", GW'(lines), GW'(3));
      chk("over_grid", grid, paint('0, 1, 19, 4, 5, 2));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("idle_state", GW'(state), '0);
      chk("idle_over", GW'(over), '0);
      chk("idle_lines", GW'(lines), '0);
      @(negedge clk);
      chk("idle_grid", grid, '0);
      pc.piece_i = 3'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive(T, 3);
      chk("spawn2", GW'(state), GW'(2));
      repeat (2) @(negedge clk);
      chk("type7_as_I", grid, paint('0, 0, 0, 3, 6, 1));
      tick = 1'b1;
      for (int i = 0; i < 40 && state != 3'd5; i++) @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      chk("in_clear", GW'(state), GW'(5));
      chk("clear_pre_rst", grid, paint('0, 19, 19, 3, 6, 1));
      nRst = 1'b0;
      #1;
      chk("arst_state", GW'(state), '0);
      chk("arst_grid", grid, '0);
      chk("arst_lines", GW'(lines), '0);
      chk("arst_req", GW'(pc.piece_req_o), '0);
      chk("arst_over", GW'(over), '0);
      #20;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
